// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: the canonical NOP word and the fetch FSM states.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_TRAP = 2'd2
  } fetch_state_e;

  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus: byte address out, instruction word back in the same cycle.
interface fetch_stage_if #(
  parameter int unsigned RegBits = 32
);
  logic [RegBits-1:0] addr;
  logic [RegBits-1:0] rdata;

  modport master  (output addr, input rdata);
  modport slave   (input addr, output rdata);
  modport monitor (input addr, input rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: captures the word on the fetch bus with its address, or holds, or bubbles.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int unsigned RegBits = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               hold_i,
  input  logic               bubble_i,
  fetch_stage_if.monitor     fetch_bus,
  output logic [RegBits-1:0] instr_o,
  output logic [RegBits-1:0] pc_o,
  output logic               valid_o
);

  logic [RegBits-1:0] instr_q;
  logic [RegBits-1:0] pc_q;
  logic               valid_q;

  // A bubble wins over hold so a redirect can flush a stalled slot.
  always_ff @(posedge clk_i) begin
    if (rst_i || bubble_i) begin
      instr_q <= RegBits'(NOP_INSTR);
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      instr_q <= fetch_bus.rdata;
      pc_q    <= fetch_bus.addr;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, BOOT/RUN/TRAP control and fetch counter feeding the IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned        RegBits   = 32,
  parameter logic [RegBits-1:0] ResetAddr = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               branch_taken_i,
  input  logic [RegBits-1:0] branch_target_i,
  output logic [RegBits-1:0] imem_addr_o,
  input  logic [RegBits-1:0] imem_rdata_i,
  output logic [RegBits-1:0] instr_o,
  output logic [RegBits-1:0] pc_o,
  output logic [RegBits-1:0] pc_plus4_o,
  output logic               valid_o,
  output logic               misaligned_o,
  output logic [31:0]        fetch_count_o,
  output fetch_state_e       state_o
);

  fetch_state_e       state_q;
  logic [RegBits-1:0] pc_q;
  logic               misaligned_q;
  logic [31:0]        count_q;

  logic in_run;
  logic redirect;
  logic advance;

  assign in_run   = (state_q == FETCH_RUN);
  assign redirect = in_run && branch_taken_i;
  assign advance  = in_run && !branch_taken_i && !stall_i;

  // Redirect beats stall beats advance; BOOT and TRAP never touch PC or counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FETCH_BOOT;
      pc_q         <= ResetAddr;
      misaligned_q <= 1'b0;
      count_q      <= '0;
    end else begin
      case (state_q)
        FETCH_BOOT: state_q <= FETCH_RUN;
        FETCH_RUN: begin
          if (branch_taken_i) begin
            if (word_aligned(branch_target_i[1:0])) begin
              pc_q <= branch_target_i;
            end else begin
              state_q      <= FETCH_TRAP;
              misaligned_q <= 1'b1;
            end
          end else if (!stall_i) begin
            pc_q    <= pc_q + RegBits'(4);
            count_q <= count_q + 32'd1;
          end
        end
        FETCH_TRAP: state_q <= FETCH_TRAP;
        default:    state_q <= FETCH_BOOT;
      endcase
    end
  end

  fetch_stage_if #(.RegBits(RegBits)) fetch_bus ();

  assign fetch_bus.addr  = pc_q;
  assign fetch_bus.rdata = imem_rdata_i;

  if_id_reg #(.RegBits(RegBits)) u_if_id (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .hold_i    (!advance),
    .bubble_i  (redirect),
    .fetch_bus (fetch_bus),
    .instr_o   (instr_o),
    .pc_o      (pc_o),
    .valid_o   (valid_o)
  );

  assign imem_addr_o   = pc_q;
  assign pc_plus4_o    = pc_o + RegBits'(4);
  assign misaligned_o  = misaligned_q;
  assign fetch_count_o = count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, compared every cycle against a reference model.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic         clk;
  logic         rst;
  logic         stall;
  logic         br_taken;
  logic [31:0]  br_target;
  logic [31:0]  instr;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         valid;
  logic         misaligned;
  logic [31:0]  fetch_count;
  fetch_state_e state;

  int checks;
  int failures;

  fetch_stage_if #(.RegBits(32)) imem ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  assign imem.rdata = mem_word(imem.addr);

  fetch_stage #(.RegBits(32), .ResetAddr(RESET_ADDR)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_i         (stall),
    .branch_taken_i  (br_taken),
    .branch_target_i (br_target),
    .imem_addr_o     (imem.addr),
    .imem_rdata_i    (imem.rdata),
    .instr_o         (instr),
    .pc_o            (pc),
    .pc_plus4_o      (pc_plus4),
    .valid_o         (valid),
    .misaligned_o    (misaligned),
    .fetch_count_o   (fetch_count),
    .state_o         (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: 0 = boot, 1 = running, 2 = trapped
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pco;
  logic        m_valid;
  logic        m_mis;
  logic [31:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_mode = 0; m_pc = RESET_ADDR; m_instr = 32'h13; m_pco = 0;
      m_valid = 0; m_mis = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (br_taken) begin
        m_instr = 32'h13; m_pco = 0; m_valid = 0;
        if (br_target % 4 != 0) begin
          m_mode = 2; m_mis = 1;
        end else begin
          m_pc = br_target;
        end
      end else if (!stall) begin
        m_instr = mem_word(m_pc);
        m_pco   = m_pc;
        m_valid = 1;
        m_pc    = m_pc + 32'd4;
        m_cnt   = m_cnt + 32'd1;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_state;
    exp_state = (m_mode == 0) ? 32'(FETCH_BOOT) : (m_mode == 1) ? 32'(FETCH_RUN) : 32'(FETCH_TRAP);
    check_eq("imem_addr", imem.addr, m_pc);
    check_eq("instr", instr, m_instr);
    check_eq("pc", pc, m_pco);
    check_eq("pc_plus4", pc_plus4, m_pco + 32'd4);
    check_eq("valid", 32'(valid), 32'(m_valid));
    check_eq("misaligned", 32'(misaligned), 32'(m_mis));
    check_eq("fetch_count", fetch_count, m_cnt);
    check_eq("state", 32'(state), exp_state);
  endtask

  // driver: apply inputs, take one edge, update model, sample #1 later
  task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] t);
    rst = r; stall = s; br_taken = b; br_target = t;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1; stall = 0; br_taken = 0; br_target = 0;
    m_mode = 0; m_pc = 0; m_instr = 0; m_pco = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
    #1;

    // reset and first fetch
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check_eq("rst_instr", instr, 32'h13);
    check_eq("rst_pc_plus4", pc_plus4, 32'd4);
    check_eq("rst_count", fetch_count, 32'd0);
    cycle(0, 0, 0, 0);
    check_eq("boot_valid", 32'(valid), 32'd0);
    check_eq("boot_addr", imem.addr, 32'd0);
    cycle(0, 0, 0, 0);
    check_eq("first_instr", instr, mem_word(32'd0));
    check_eq("first_pc", pc, 32'd0);
    check_eq("first_valid", 32'(valid), 32'd1);

    // stall at pc 8
    cycle(0, 0, 0, 0);
    check_eq("pre_stall_addr", imem.addr, 32'd8);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0);
      check_eq("stall_addr", imem.addr, 32'd8);
      check_eq("stall_pc", pc, 32'd4);
      check_eq("stall_count", fetch_count, 32'd2);
    end
    cycle(0, 0, 0, 0);
    check_eq("resume_pc", pc, 32'd8);
    check_eq("resume_addr", imem.addr, 32'd12);

    // redirect beats stall
    cycle(0, 1, 1, 32'h100);
    check_eq("redir_addr", imem.addr, 32'h100);
    check_eq("redir_valid", 32'(valid), 32'd0);
    check_eq("redir_instr", instr, 32'h13);
    cycle(0, 0, 0, 0);
    check_eq("redir_pc", pc, 32'h100);
    check_eq("redir_valid2", 32'(valid), 32'd1);

    // PC wrap
    cycle(0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    check_eq("wrap_pc", pc, 32'hFFFF_FFFC);
    check_eq("wrap_plus4", pc_plus4, 32'd0);
    check_eq("wrap_addr", imem.addr, 32'd0);

    // reset while stalled at 0x40
    cycle(0, 0, 1, 32'h40);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check_eq("midstall_addr", imem.addr, RESET_ADDR);
    check_eq("midstall_state", 32'(state), 32'(FETCH_BOOT));
    check_eq("midstall_count", fetch_count, 32'd0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // misaligned redirect traps until reset
    cycle(0, 0, 1, 32'h102);
    check_eq("trap_mis", 32'(misaligned), 32'd1);
    check_eq("trap_valid", 32'(valid), 32'd0);
    check_eq("trap_addr", imem.addr, 32'd8);
    cycle(0, 0, 1, 32'h200);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    check_eq("trap_hold_addr", imem.addr, 32'd8);
    check_eq("trap_hold_mis", 32'(misaligned), 32'd1);
    cycle(1, 0, 0, 0);
    check_eq("trap_clear", 32'(misaligned), 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic        r, s, b;
      logic [31:0] t;
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      t = {$urandom_range(0, 32'hFFFF) , 16'h0} | 32'($urandom_range(0, 16'hFFFF));
      if ($urandom_range(0, 15) != 0) t[1:0] = 2'b00;
      cycle(r, s, b, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
